// File: rtl/game_session_ctrl_pkg.sv
// Shared types and constants for the 2048 session controller.
// Holds state encodings, key bit positions and board geometry.
package game_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_PLAY   = 3'd1,
    ST_SETTLE = 3'd2,
    ST_CHECK  = 3'd3,
    ST_WIN    = 3'd4,
    ST_LOSE   = 3'd5
  } state_e;

  localparam int KEY_UP    = 0;
  localparam int KEY_DOWN  = 1;
  localparam int KEY_LEFT  = 2;
  localparam int KEY_RIGHT = 3;

  localparam int CELL_W  = 4;
  localparam int N_CELLS = 16;
  localparam int BOARD_W = 64;

  localparam logic MODE_EASY = 1'b0;
  localparam logic MODE_FUN  = 1'b1;

  function automatic logic is_onehot4(input logic [3:0] v);
    return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
  endfunction

endpackage

// File: rtl/game_session_ctrl_board_eval.sv
// Combinational board classifier: winning cell present, board full,
// and whether any horizontal or vertical neighbour pair can merge.
module board_eval
  import game_pkg::*;
(
  input  logic [BOARD_W-1:0] board,
  input  logic [CELL_W-1:0]  win_exp,
  output logic               has_win,
  output logic               is_full,
  output logic               can_merge
);

  logic [CELL_W-1:0] cells [N_CELLS];

  always_comb begin
    for (int i = 0; i < N_CELLS; i++) cells[i] = board[i*CELL_W +: CELL_W];
  end

  always_comb begin
    has_win   = 1'b0;
    is_full   = 1'b1;
    can_merge = 1'b0;
    for (int i = 0; i < N_CELLS; i++) begin
      if (cells[i] == win_exp) has_win = 1'b1;
      if (cells[i] == '0)      is_full = 1'b0;
    end
    // row r, column c -> index 4r+c; compare c with c+1
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 3; c++) begin
        if (cells[4*r+c] == cells[4*r+c+1]) can_merge = 1'b1;
      end
    end
    for (int i = 0; i < N_CELLS - 4; i++) begin
      if (cells[i] == cells[i+4]) can_merge = 1'b1;
    end
  end

endmodule

// File: rtl/game_session_ctrl.sv
// Session controller between keypad/switches and the easy/fun engines:
// latches mode, gates move pulses, waits for the board to settle, judges it.
module game_session_ctrl
  import game_pkg::*;
#(
  parameter int          SETTLE_CYCLES = 8,
  parameter logic [3:0]  WIN_EXP       = 4'd11
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [3:0]          mode_sel,
  input  logic [3:0]          key_in,
  input  logic [BOARD_W-1:0]  num_a,
  input  logic [BOARD_W-1:0]  num_b,
  input  logic [15:0]         judge_a,
  input  logic [15:0]         judge_b,
  output logic [3:0]          key_a,
  output logic [3:0]          key_b,
  output logic [BOARD_W-1:0]  num_out,
  output logic [15:0]         judge_out,
  output logic [2:0]          state,
  output logic [15:0]         move_cnt,
  output logic                win,
  output logic                lose
);

  localparam logic [7:0] SETTLE_LD = 8'(SETTLE_CYCLES);

  state_e               state_q;
  logic                 sel_q;
  logic [3:0]           prev_key_q;
  logic                 prev_start_q;
  logic [7:0]           cnt_q;
  logic [BOARD_W-1:0]   snap_q;
  logic [15:0]          move_cnt_q;
  logic [3:0]           key_a_q, key_b_q;
  logic [BOARD_W-1:0]   num_q;
  logic [15:0]          judge_q;
  logic                 win_q, lose_q;

  logic [3:0]           key_rise_d;
  logic                 key_ev_d, start_rise_d, sel_mode_d;
  logic [BOARD_W-1:0]   board_sel;
  logic                 has_win, is_full, can_merge;
  logic                 unused_mode;

  assign unused_mode  = ^mode_sel[3:2];
  assign key_rise_d   = key_in & ~prev_key_q;
  assign key_ev_d     = is_onehot4(key_rise_d);
  assign start_rise_d = start & ~prev_start_q;
  // easy takes precedence when both mode bits are set
  assign sel_mode_d   = (mode_sel[1:0] == 2'b10) ? MODE_FUN : MODE_EASY;
  assign board_sel    = sel_q ? num_b : num_a;

  board_eval u_eval (
    .board     (board_sel),
    .win_exp   (WIN_EXP),
    .has_win   (has_win),
    .is_full   (is_full),
    .can_merge (can_merge)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      sel_q        <= MODE_EASY;
      prev_key_q   <= '0;
      prev_start_q <= 1'b0;
      cnt_q        <= '0;
      snap_q       <= '0;
      move_cnt_q   <= '0;
      key_a_q      <= '0;
      key_b_q      <= '0;
      num_q        <= '0;
      judge_q      <= '0;
      win_q        <= 1'b0;
      lose_q       <= 1'b0;
    end else begin
      prev_key_q   <= key_in;
      prev_start_q <= start;
      num_q        <= board_sel;
      judge_q      <= sel_q ? judge_b : judge_a;
      key_a_q      <= '0;
      key_b_q      <= '0;
      if (start_rise_d) begin
        sel_q      <= sel_mode_d;
        move_cnt_q <= '0;
        cnt_q      <= '0;
        win_q      <= 1'b0;
        lose_q     <= 1'b0;
        state_q    <= ST_PLAY;
      end else begin
        case (state_q)
          ST_PLAY: begin
            if (key_ev_d) begin
              if (sel_q == MODE_FUN) key_b_q <= key_rise_d;
              else                   key_a_q <= key_rise_d;
              snap_q  <= board_sel;
              cnt_q   <= SETTLE_LD;
              state_q <= ST_SETTLE;
            end
          end
          // counts SETTLE_LD..0 then one more cycle: CHECK lands SETTLE_CYCLES+1 after the pulse
          ST_SETTLE: begin
            if (cnt_q == 8'd0) state_q <= ST_CHECK;
            else               cnt_q   <= cnt_q - 8'd1;
          end
          ST_CHECK: begin
            if (board_sel != snap_q && move_cnt_q != 16'hFFFF)
              move_cnt_q <= move_cnt_q + 16'd1;
            if (has_win) begin
              win_q   <= 1'b1;
              state_q <= ST_WIN;
            end else if (is_full && !can_merge) begin
              lose_q  <= 1'b1;
              state_q <= ST_LOSE;
            end else begin
              state_q <= ST_PLAY;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign key_a     = key_a_q;
  assign key_b     = key_b_q;
  assign num_out   = num_q;
  assign judge_out = judge_q;
  assign state     = state_q;
  assign move_cnt  = move_cnt_q;
  assign win       = win_q;
  assign lose      = lose_q;

endmodule
